// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
// Holds width defaults and port-index encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;

    typedef logic port_t;

    localparam port_t PORT_A = 1'b0;
    localparam port_t PORT_B = 1'b1;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus: two requester ports plus the register-heap write port.
// The arbiter uses the slave view; requesters and the heap use the master view.
interface reg_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;

    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] W;
    logic              s_write;
    logic [31:0]       pending;

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output rd, W, s_write, pending
    );

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  rd, W, s_write, pending
    );

endinterface

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a writeback port.
// Loads on transfer, empties on grant unless reloaded in the same cycle.
module wb_hold_slot
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_i,
    input  logic              grant_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Next entry: a new transfer wins over the grant-driven clear.
    always_comb begin
        full_d = load_i | (full_q & ~grant_i);
        addr_d = load_i ? addr_i : addr_q;
        data_d = load_i ? data_i : data_q;
    end

    // Entry state; clr drops the entry at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Two-port writeback arbiter in front of the register heap.
// Age ordering on same-address hazards, round-robin otherwise.
module reg_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    reg_wb_arbiter_if.slave      bus
);

    logic              a_full, b_full;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_dat, b_dat;
    logic              a_load, b_load;
    logic              grant_a, grant_b;
    logic              a_nx, b_nx;
    port_t             pick;
    port_t             older_q, older_d;
    port_t             rr_q, rr_d;
    logic [31:0]       pend;

    assign a_load = bus.a_valid & bus.a_ready;
    assign b_load = bus.b_valid & bus.b_ready;

    assign bus.a_ready = ~a_full | grant_a;
    assign bus.b_ready = ~b_full | grant_b;

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clk(clk), .clr(clr),
        .load_i(a_load), .grant_i(grant_a),
        .addr_i(bus.a_rd), .data_i(bus.a_data),
        .full_o(a_full), .addr_o(a_addr), .data_o(a_dat)
    );

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
        .clk(clk), .clr(clr),
        .load_i(b_load), .grant_i(grant_b),
        .addr_i(bus.b_rd), .data_i(bus.b_data),
        .full_o(b_full), .addr_o(b_addr), .data_o(b_dat)
    );

    // Pick one full entry: older first on a real same-register clash.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        pick    = rr_q;
        if (a_full && b_full) begin
            if (a_addr == b_addr && a_addr != '0) pick = older_q;
            grant_a = (pick == PORT_A);
            grant_b = (pick == PORT_B);
        end else begin
            grant_a = a_full;
            grant_b = b_full;
        end
    end

    // Heap write port from the granted entry; register 0 is never written.
    always_comb begin
        bus.rd      = '0;
        bus.W       = '0;
        bus.s_write = 1'b0;
        unique case (1'b1)
            grant_a: begin
                bus.rd      = a_addr;
                bus.W       = a_dat;
                bus.s_write = (a_addr != '0);
            end
            grant_b: begin
                bus.rd      = b_addr;
                bus.W       = b_dat;
                bus.s_write = (b_addr != '0);
            end
            default: ;
        endcase
    end

    // Age and pointer update; a same-edge pair counts A as older.
    always_comb begin
        a_nx    = a_load | (a_full & ~grant_a);
        b_nx    = b_load | (b_full & ~grant_b);
        older_d = older_q;
        rr_d    = rr_q;
        if (a_nx && b_nx) begin
            if (a_load && !b_load)      older_d = PORT_B;
            else if (b_load)            older_d = PORT_A;
        end
        if (a_full && b_full)
            rr_d = grant_a ? PORT_B : PORT_A;
    end

    // Arbitration state, cleared to favour A.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            older_q <= PORT_A;
            rr_q    <= PORT_A;
        end else begin
            older_q <= older_d;
            rr_q    <= rr_d;
        end
    end

    // Scoreboard bits for every held, unissued nonzero destination.
    always_comb begin
        pend = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (a_full && int'(a_addr) == i) pend[i] = 1'b1;
            if (b_full && int'(b_addr) == i) pend[i] = 1'b1;
        end
    end

    assign bus.pending = pend;

endmodule
